// File: rtl/latq_multi_capture.sv
// Multi-channel clocked replacement for a transparent latch: per-channel capture
// registers with level, rise, fall (latch-close) and freeze modes plus a minimum-open-window check.
module latq_multi_capture #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MIN_OPEN = 2
) (
    input  logic                      CLK,
    input  logic                      RN,
    input  logic [CHANNELS-1:0]       E,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [1:0]                MODE,
    input  logic                      CLR_VIOL,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       Q_VLD,
    output logic [CHANNELS-1:0]       UPD,
    output logic [CHANNELS-1:0]       VIOL
);

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_RISE   = 2'b01,
        MODE_FALL   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_t;

    localparam int CW = (MIN_OPEN < 1) ? 1 : $clog2(MIN_OPEN + 1);
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_OPEN);

    mode_t mode;
    assign mode = mode_t'(MODE);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic             e_q;
        logic [CW-1:0]    cnt;
        logic [WIDTH-1:0] shadow;
        logic [WIDTH-1:0] q_r;
        logic             vld_r;
        logic             upd_r;
        logic             viol_r;
        logic             rise;
        logic             fall;
        logic             load;
        logic             viol_set;
        logic [WIDTH-1:0] load_val;

        // Fall mode loads the shadow so Q reflects the last D seen while E was high.
        always_comb begin
            rise     = E[c] & ~e_q;
            fall     = ~E[c] & e_q;
            load     = 1'b0;
            load_val = D[c*WIDTH +: WIDTH];
            case (mode)
                MODE_LEVEL: load = E[c];
                MODE_RISE:  load = rise;
                MODE_FALL: begin
                    load     = fall;
                    load_val = shadow;
                end
                default:    load = 1'b0;
            endcase
            viol_set = fall && (mode != MODE_FREEZE) && (cnt < MIN_CNT);
        end

        always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
                e_q    <= 1'b0;
                cnt    <= '0;
                shadow <= '0;
                q_r    <= '0;
                vld_r  <= 1'b0;
                upd_r  <= 1'b0;
                viol_r <= 1'b0;
            end else begin
                e_q <= E[c];
                if (rise)
                    cnt <= CW'(1);
                else if (E[c]) begin
                    if (cnt < MIN_CNT)
                        cnt <= cnt + CW'(1);
                end else if (fall)
                    cnt <= '0;
                if (E[c] && (mode != MODE_FREEZE))
                    shadow <= D[c*WIDTH +: WIDTH];
                if (load)
                    q_r <= load_val;
                vld_r  <= vld_r | load;
                upd_r  <= load;
                // A violation setting in the same cycle as a clear takes priority.
                viol_r <= viol_set | (viol_r & ~CLR_VIOL);
            end
        end

        assign Q[c*WIDTH +: WIDTH] = q_r;
        assign Q_VLD[c]            = vld_r;
        assign UPD[c]              = upd_r;
        assign VIOL[c]             = viol_r;
    end

endmodule

// File: tb/tb_latq_multi_capture.sv
// Directed, table-driven bench for latq_multi_capture with hand-computed expectations,
// plus hand sequences for reset and a MIN_OPEN=1 instance.
module tb_latq_multi_capture;

    logic        CLK;
    logic        RN;
    logic [3:0]  E;
    logic [31:0] D;
    logic [1:0]  MODE;
    logic        CLR_VIOL;
    logic [31:0] Q;
    logic [3:0]  Q_VLD;
    logic [3:0]  UPD;
    logic [3:0]  VIOL;
    logic [31:0] q1;
    logic [3:0]  vld1;
    logic [3:0]  upd1;
    logic [3:0]  viol1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0]  e;
        logic [31:0] d;
        logic [1:0]  mode;
        logic        clr;
        logic [31:0] q;
        logic [3:0]  vld;
        logic [3:0]  upd;
        logic [3:0]  viol;
    } vec_t;

    vec_t vecs[39];

    latq_multi_capture #(.WIDTH(8), .CHANNELS(4), .MIN_OPEN(2)) dut (
        .CLK(CLK), .RN(RN), .E(E), .D(D), .MODE(MODE), .CLR_VIOL(CLR_VIOL),
        .Q(Q), .Q_VLD(Q_VLD), .UPD(UPD), .VIOL(VIOL)
    );

    latq_multi_capture #(.WIDTH(8), .CHANNELS(4), .MIN_OPEN(1)) dut1 (
        .CLK(CLK), .RN(RN), .E(E), .D(D), .MODE(MODE), .CLR_VIOL(CLR_VIOL),
        .Q(q1), .Q_VLD(vld1), .UPD(upd1), .VIOL(viol1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] e, input logic [31:0] d,
                                 input logic [1:0] mode, input logic clr);
        E        = e;
        D        = d;
        MODE     = mode;
        CLR_VIOL = clr;
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] q, input logic [3:0] vld,
                               input logic [3:0] upd, input logic [3:0] viol);
        checkValue({name, ".Q"},     Q,            q);
        checkValue({name, ".Q_VLD"}, {28'h0, Q_VLD}, {28'h0, vld});
        checkValue({name, ".UPD"},   {28'h0, UPD},   {28'h0, upd});
        checkValue({name, ".VIOL"},  {28'h0, VIOL},  {28'h0, viol});
    endtask

    initial begin
        //            e     d             mode clr  q             vld   upd   viol
        vecs[0]  = '{4'h1, 32'h000000A5, 2'd0, 1'b0, 32'h000000A5, 4'h1, 4'h1, 4'h0};
        vecs[1]  = '{4'h1, 32'h000000A5, 2'd0, 1'b0, 32'h000000A5, 4'h1, 4'h1, 4'h0};
        vecs[2]  = '{4'h0, 32'h00000000, 2'd0, 1'b0, 32'h000000A5, 4'h1, 4'h0, 4'h0};
        vecs[3]  = '{4'h2, 32'h00000100, 2'd0, 1'b0, 32'h000001A5, 4'h3, 4'h2, 4'h0};
        vecs[4]  = '{4'h2, 32'h00000200, 2'd0, 1'b0, 32'h000002A5, 4'h3, 4'h2, 4'h0};
        vecs[5]  = '{4'h2, 32'h00000300, 2'd0, 1'b0, 32'h000003A5, 4'h3, 4'h2, 4'h0};
        vecs[6]  = '{4'h2, 32'h00000400, 2'd0, 1'b0, 32'h000004A5, 4'h3, 4'h2, 4'h0};
        vecs[7]  = '{4'h0, 32'h00000500, 2'd0, 1'b0, 32'h000004A5, 4'h3, 4'h0, 4'h0};
        vecs[8]  = '{4'h2, 32'h00000100, 2'd1, 1'b0, 32'h000001A5, 4'h3, 4'h2, 4'h0};
        vecs[9]  = '{4'h2, 32'h00000200, 2'd1, 1'b0, 32'h000001A5, 4'h3, 4'h0, 4'h0};
        vecs[10] = '{4'h2, 32'h00000300, 2'd1, 1'b0, 32'h000001A5, 4'h3, 4'h0, 4'h0};
        vecs[11] = '{4'h2, 32'h00000400, 2'd1, 1'b0, 32'h000001A5, 4'h3, 4'h0, 4'h0};
        vecs[12] = '{4'h0, 32'h00000000, 2'd1, 1'b0, 32'h000001A5, 4'h3, 4'h0, 4'h0};
        vecs[13] = '{4'h4, 32'h00100000, 2'd2, 1'b0, 32'h000001A5, 4'h3, 4'h0, 4'h0};
        vecs[14] = '{4'h4, 32'h00200000, 2'd2, 1'b0, 32'h000001A5, 4'h3, 4'h0, 4'h0};
        vecs[15] = '{4'h4, 32'h00300000, 2'd2, 1'b0, 32'h000001A5, 4'h3, 4'h0, 4'h0};
        vecs[16] = '{4'h0, 32'h00FF0000, 2'd2, 1'b0, 32'h003001A5, 4'h7, 4'h4, 4'h0};
        vecs[17] = '{4'h0, 32'h00000000, 2'd2, 1'b0, 32'h003001A5, 4'h7, 4'h0, 4'h0};
        vecs[18] = '{4'h8, 32'h77000000, 2'd1, 1'b0, 32'h773001A5, 4'hF, 4'h8, 4'h0};
        vecs[19] = '{4'h0, 32'h00000000, 2'd1, 1'b0, 32'h773001A5, 4'hF, 4'h0, 4'h8};
        vecs[20] = '{4'h0, 32'h00000000, 2'd1, 1'b1, 32'h773001A5, 4'hF, 4'h0, 4'h0};
        vecs[21] = '{4'h8, 32'h88000000, 2'd1, 1'b0, 32'h883001A5, 4'hF, 4'h8, 4'h0};
        vecs[22] = '{4'h0, 32'h00000000, 2'd1, 1'b1, 32'h883001A5, 4'hF, 4'h0, 4'h8};
        vecs[23] = '{4'h0, 32'h00000000, 2'd1, 1'b0, 32'h883001A5, 4'hF, 4'h0, 4'h8};
        vecs[24] = '{4'h1, 32'h000000C3, 2'd1, 1'b0, 32'h883001C3, 4'hF, 4'h1, 4'h8};
        vecs[25] = '{4'h1, 32'h000000D4, 2'd2, 1'b0, 32'h883001C3, 4'hF, 4'h0, 4'h8};
        vecs[26] = '{4'h0, 32'h000000EE, 2'd2, 1'b0, 32'h883001D4, 4'hF, 4'h1, 4'h8};
        vecs[27] = '{4'h2, 32'h00005A00, 2'd2, 1'b0, 32'h883001D4, 4'hF, 4'h0, 4'h8};
        vecs[28] = '{4'h0, 32'h00000000, 2'd2, 1'b0, 32'h88305AD4, 4'hF, 4'h2, 4'hA};
        vecs[29] = '{4'h0, 32'h00000000, 2'd2, 1'b1, 32'h88305AD4, 4'hF, 4'h0, 4'h0};
        vecs[30] = '{4'hF, 32'h11223344, 2'd3, 1'b0, 32'h88305AD4, 4'hF, 4'h0, 4'h0};
        vecs[31] = '{4'h0, 32'h55667788, 2'd3, 1'b0, 32'h88305AD4, 4'hF, 4'h0, 4'h0};
        vecs[32] = '{4'h5, 32'h99AABBCC, 2'd3, 1'b0, 32'h88305AD4, 4'hF, 4'h0, 4'h0};
        vecs[33] = '{4'hA, 32'hDDEEFF00, 2'd3, 1'b0, 32'h88305AD4, 4'hF, 4'h0, 4'h0};
        vecs[34] = '{4'h0, 32'h00000000, 2'd3, 1'b0, 32'h88305AD4, 4'hF, 4'h0, 4'h0};
        vecs[35] = '{4'h4, 32'h00990000, 2'd3, 1'b0, 32'h88305AD4, 4'hF, 4'h0, 4'h0};
        vecs[36] = '{4'h4, 32'h00990000, 2'd3, 1'b0, 32'h88305AD4, 4'hF, 4'h0, 4'h0};
        vecs[37] = '{4'h0, 32'h00000000, 2'd2, 1'b0, 32'h88305AD4, 4'hF, 4'h4, 4'h0};
        vecs[38] = '{4'h0, 32'h00000000, 2'd0, 1'b0, 32'h88305AD4, 4'hF, 4'h0, 4'h0};

        // Reset held with every input active: all outputs must stay cleared.
        RN = 1'b0;
        applyStimulus(4'hF, 32'hFFFFFFFF, 2'd0, 1'b0);
        #1;
        checkOutput("reset_async", 32'h0, 4'h0, 4'h0, 4'h0);
        tick();
        tick();
        checkOutput("reset_held", 32'h0, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'h0, 32'h0, 2'd0, 1'b0);
        RN = 1'b1;

        for (int i = 0; i < 39; i++) begin
            applyStimulus(vecs[i].e, vecs[i].d, vecs[i].mode, vecs[i].clr);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].q, vecs[i].vld, vecs[i].upd, vecs[i].viol);
            checkValue($sformatf("vec%0d.VIOL_min1", i), {28'h0, viol1}, 32'h0);
        end

        // Reset in the second cycle of a rise-mode window, released with E still high.
        applyStimulus(4'h1, 32'h000000AB, 2'd1, 1'b0);
        tick();
        checkOutput("midwin_open", 32'h88305AAB, 4'hF, 4'h1, 4'h0);
        RN = 1'b0;
        #1;
        checkOutput("midwin_rst_async", 32'h0, 4'h0, 4'h0, 4'h0);
        tick();
        checkOutput("midwin_rst_edge", 32'h0, 4'h0, 4'h0, 4'h0);
        D  = 32'h000000CD;
        RN = 1'b1;
        tick();
        checkOutput("midwin_release", 32'h000000CD, 4'h1, 4'h1, 4'h0);
        tick();
        checkOutput("midwin_hold", 32'h000000CD, 4'h1, 4'h0, 4'h0);
        applyStimulus(4'h0, 32'h0, 2'd1, 1'b0);
        tick();
        checkOutput("midwin_close", 32'h000000CD, 4'h1, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
